// File: rtl/world_sel_ctrl.sv
// world_sel_ctrl: button/auto-rotate city selector committing world_sel on LCD frame boundaries
module world_sel_ctrl #(
  parameter int NUM_CITIES  = 5,
  parameter int DEB_CYCLES  = 20,
  parameter int AUTO_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       auto_en,
  input  logic       frame_done,
  output logic [2:0] world_sel,
  output logic       pending,
  output logic [7:0] led_sel
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int AW = $clog2(AUTO_FRAMES + 1);
  localparam logic [2:0] LAST = 3'(NUM_CITIES - 1);
  typedef enum logic {IDLE, WAIT_FRAME} state_t;
  state_t state, state_nxt;
  logic [1:0] s1, s2, stb, stb_d, prs;
  logic [DW-1:0] cnt [2];
  logic [AW-1:0] acnt, acnt_nxt;
  logic [2:0] target, target_nxt, inc, dec, ws_nxt;
  logic [7:0] led_nxt;
  logic step, commit, pend_nxt;
  assign inc = (target == LAST) ? 3'd0 : target + 3'd1;
  assign dec = (target == 3'd0) ? LAST : target - 3'd1;
  // button sync, debounce and registered press pulse; bit 0 = next, bit 1 = prev
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      stb <= '0;
      stb_d <= '0;
      prs <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1 <= {btn_prev, btn_next};
      s2 <= s1;
      stb_d <= stb;
      prs <= stb & ~stb_d;
      for (int i = 0; i < 2; i++)
        if (s2[i] == stb[i]) cnt[i] <= '0;
        else if (cnt[i] == DW'(DEB_CYCLES - 1)) begin
          stb[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  // auto-rotate frame counting and target selection; presses override and restart the count
  always_comb begin
    step = 1'b0;
    acnt_nxt = acnt;
    if (|prs || !auto_en) acnt_nxt = '0;
    else if (frame_done && state == IDLE) begin
      step = acnt == AW'(AUTO_FRAMES - 1);
      acnt_nxt = step ? '0 : acnt + 1'b1;
    end
    target_nxt = (prs == 2'b01) ? inc : (prs == 2'b10) ? dec : step ? inc : target;
  end
  // state, target and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      target <= '0;
      acnt <= '0;
      world_sel <= '0;
      led_sel <= 8'h01;
      pending <= 1'b0;
    end else begin
      state <= state_nxt;
      target <= target_nxt;
      acnt <= acnt_nxt;
      world_sel <= ws_nxt;
      led_sel <= led_nxt;
      pending <= pend_nxt;
    end
  // next state: leave IDLE on target change, return on commit or when the target comes back
  always_comb
    state_nxt = (state == IDLE) ? ((target != world_sel) ? WAIT_FRAME : IDLE)
                                : ((frame_done || target == world_sel) ? IDLE : WAIT_FRAME);
  // commit takes the post-update target so a same-cycle press is not lost
  always_comb begin
    commit = state == WAIT_FRAME && frame_done;
    ws_nxt = commit ? target_nxt : world_sel;
    led_nxt = commit ? 8'd1 << target_nxt : led_sel;
    pend_nxt = state_nxt == WAIT_FRAME;
  end
endmodule

// File: tb/tb_world_sel_ctrl.sv
// tb_world_sel_ctrl: scoreboard bench for world_sel_ctrl commits, latency and pending behaviour
module tb_world_sel_ctrl;
  logic clk = 1'b0, rst = 1'b1, btn_next = 1'b0, btn_prev = 1'b0, auto_en = 1'b0, frame_done = 1'b0;
  logic [2:0] world_sel;
  logic pending;
  logic [7:0] led_sel;
  int errs = 0, checks = 0;
  int exp_q[$];
  int e;
  logic [2:0] prev_ws = 3'd0;
  world_sel_ctrl #(.NUM_CITIES(5), .DEB_CYCLES(4), .AUTO_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev), .auto_en(auto_en),
    .frame_done(frame_done), .world_sel(world_sel), .pending(pending), .led_sel(led_sel)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press(logic nx, logic pv);
    btn_next = nx;
    btn_prev = pv;
    tick(12);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    tick(12);
  endtask
  task automatic frame(int v);
    if (v >= 0) exp_q.push_back(v);
    frame_done = 1'b1;
    tick(1);
    frame_done = 1'b0;
    tick(3);
  endtask
  // every world_sel change must match the next queued commit
  always @(negedge clk)
    if (rst) prev_ws = 3'd0;
    else if (world_sel != prev_ws) begin
      if (exp_q.size() == 0) chk("ws_unexpected", int'(world_sel), int'(prev_ws));
      else begin
        e = exp_q.pop_front();
        chk("ws_commit", int'(world_sel), e);
        chk("led_commit", int'(led_sel), 1 << e);
      end
      prev_ws = world_sel;
    end
  initial begin
    tick(3);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(10);
      chk("rst_ws", int'(world_sel), 0);
      chk("rst_led", int'(led_sel), 1);
      chk("rst_pend", int'(pending), 0);
    end
    btn_next = 1'b1;
    tick(3);
    btn_next = 1'b0;
    tick(20);
    chk("noise_pend", int'(pending), 0);
    btn_next = 1'b1;
    tick(8);
    chk("lat_pend_lo", int'(pending), 0);
    tick(1);
    chk("lat_pend_hi", int'(pending), 1);
    tick(5);
    btn_next = 1'b0;
    tick(12);
    frame(1);
    chk("commit_pend", int'(pending), 0);
    press(1'b0, 1'b1);
    frame(0);
    press(1'b0, 1'b1);
    frame(4);
    press(1'b1, 1'b0);
    frame(0);
    for (int v = 4; v >= 1; v--) begin
      press(1'b0, 1'b1);
      frame(v);
    end
    press(1'b0, 1'b1);
    frame(0);
    repeat (3) press(1'b1, 1'b0);
    chk("multi_pend", int'(pending), 1);
    frame(3);
    chk("multi_pend_clr", int'(pending), 0);
    press(1'b1, 1'b1);
    chk("simul_pend", int'(pending), 0);
    frame(-1);
    chk("simul_ws", int'(world_sel), 3);
    press(1'b1, 1'b0);
    chk("cancel_pend_hi", int'(pending), 1);
    press(1'b0, 1'b1);
    chk("cancel_pend_lo", int'(pending), 0);
    frame(-1);
    chk("cancel_ws", int'(world_sel), 3);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    frame(0);
    auto_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(46);
      frame(k == 4 ? 1 : k == 8 ? 2 : -1);
      chk("auto_pend", int'(pending), int'(k % 4 == 3));
    end
    for (int k = 0; k < 2; k++) begin
      tick(46);
      frame(-1);
    end
    press(1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick(46);
      frame(-1);
    end
    chk("clr_pend", int'(pending), 0);
    chk("clr_ws", int'(world_sel), 2);
    tick(46);
    frame(-1);
    chk("clr_step_pend", int'(pending), 1);
    tick(46);
    frame(3);
    auto_en = 1'b0;
    press(1'b1, 1'b0);
    chk("pre_rst_pend", int'(pending), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_ws", int'(world_sel), 0);
    chk("async_rst_pend", int'(pending), 0);
    chk("async_rst_led", int'(led_sel), 1);
    tick(2);
    rst = 1'b0;
    tick(30);
    chk("post_rst_ws", int'(world_sel), 0);
    chk("post_rst_pend", int'(pending), 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
